// File: rtl/addsub_acc_pkg.sv
// Shared constants for the addsub_acc accumulator: command codes, FSM state
// codes and the default datapath width.
package addsub_acc_pkg;

  localparam int ACC_WIDTH = 4;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit ripple adder-subtractor: S = A + (B ^ {M}) + M,
// Cout is the carry out of the top bit.
module addsub_core
  import addsub_acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] bx;

  assign bx   = B ^ {WIDTH{M}};
  assign c[0] = M;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign S[i]   = A[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
  end

  assign Cout = c[WIDTH];

endmodule

// File: rtl/addsub_acc.sv
// Registered accumulator around addsub_core with valid/ready command and
// result handshakes. Define ACC_SAT_EN to clamp acc on signed overflow.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid holds until that edge, ready never depends on valid.
module addsub_acc
  import addsub_acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] operand_q;
  logic             sub_m;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH-1:0] bx;
  logic             ovf_calc;
  logic [WIDTH-1:0] arith_res;

  assign sub_m = (op_q == OP_SUB);

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .A    (acc),
    .B    (operand_q),
    .M    (sub_m),
    .S    (sum),
    .Cout (cout)
  );

  assign bx       = operand_q ^ {WIDTH{sub_m}};
  assign ovf_calc = (acc[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);

`ifdef ACC_SAT_EN
  // On overflow the true result has the sign of A, so clamp toward it.
  always_comb begin
    arith_res = sum;
    if (ovf_calc) begin
      arith_res = acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign arith_res = sum;
`endif

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_ADD;
      operand_q <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q      <= op;
            operand_q <= operand;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_ADD, OP_SUB: begin
              acc   <= arith_res;
              carry <= cout;
              ovf   <= ovf_calc;
            end
            OP_LOAD: begin
              acc   <= operand_q;
              carry <= 1'b0;
              ovf   <= 1'b0;
            end
            default: begin
              acc   <= '0;
              carry <= 1'b0;
              ovf   <= 1'b0;
            end
          endcase
          state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_acc.sv
// Self-checking bench for addsub_acc: directed arithmetic cases, mid-command
// reset, backpressure and a short random run against a reference model.
module tb_addsub_acc;
  import addsub_acc_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] operand;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] acc;
  logic         carry;
  logic         ovf;
  logic [1:0]   state_dbg;

  logic [W+1:0] exp_q[$];
  int           n_checks;
  int           n_pass;

  logic [W-1:0] m_acc;
  logic         m_carry;
  logic         m_ovf;

  addsub_acc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand   (operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .carry     (carry),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: integer arithmetic, overflow from the true signed result.
  task automatic model_step(input logic [1:0] c_op, input logic [W-1:0] b);
    int mask;
    int sa;
    int sb;
    int raw;
    int tv;
    mask = (1 << W) - 1;
    sa   = m_acc[W-1] ? int'(m_acc) - (1 << W) : int'(m_acc);
    sb   = b[W-1] ? int'(b) - (1 << W) : int'(b);
    case (c_op)
      OP_ADD, OP_SUB: begin
        if (c_op == OP_ADD) begin
          raw = int'(m_acc) + int'(b);
          tv  = sa + sb;
        end else begin
          raw = int'(m_acc) + ((~int'(b)) & mask) + 1;
          tv  = sa - sb;
        end
        m_carry = ((raw >> W) & 1) != 0;
        m_ovf   = (tv > (1 << (W-1)) - 1) || (tv < -(1 << (W-1)));
        m_acc   = raw[W-1:0];
`ifdef ACC_SAT_EN
        if (m_ovf) m_acc = (tv > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
      end
      OP_LOAD: begin
        m_acc   = b;
        m_carry = 1'b0;
        m_ovf   = 1'b0;
      end
      default: begin
        m_acc   = '0;
        m_carry = 1'b0;
        m_ovf   = 1'b0;
      end
    endcase
    exp_q.push_back({m_acc, m_carry, m_ovf});
  endtask

  // driver: one full command/result transaction, called at a negedge
  task automatic do_txn(input logic [1:0] c_op, input logic [W-1:0] b, input int hold);
    int           waited;
    logic [W+1:0] exp;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op       = c_op;
    operand  = b;
    model_step(c_op, b);
    @(negedge clk);
    in_valid = 1'b0;
    op       = 2'($urandom_range(0, 3));
    operand  = W'($urandom_range(0, (1 << W) - 1));
    check("exec_out_valid", 32'(out_valid), 32'd0);
    check("exec_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("done_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 1);
      @(negedge clk);
      exp = exp_q[0];
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_acc", 32'(acc), 32'(exp[W+1:2]));
    end
    in_valid = 1'b0;
    // scoreboard: pop and compare the presented result
    exp = exp_q.pop_front();
    check("acc", 32'(acc), 32'(exp[W+1:2]));
    check("carry", 32'(carry), 32'(exp[1]));
    check("ovf", 32'(ovf), 32'(exp[0]));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    m_acc     = '0;
    m_carry   = 1'b0;
    m_ovf     = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = OP_ADD;
    operand   = '0;
    out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_state", 32'(state_dbg), 32'(S_IDLE));
    check("rel_carry", 32'(carry), 32'd0);
    check("rel_ovf", 32'(ovf), 32'd0);

    // reset while a LOAD 0101 is executing
    in_valid = 1'b1;
    op       = OP_LOAD;
    operand  = 4'b0101;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_acc", 32'(acc), 32'd0);
    check("mid_rst_carry", 32'(carry), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready1", 32'(in_ready), 32'd1);

    // directed arithmetic
    do_txn(OP_LOAD, 4'b0100, 0);
    do_txn(OP_ADD,  4'b0100, 0);
`ifndef ACC_SAT_EN
    check("add_ovf_wrap_acc", 32'(acc), 32'b1000);
`else
    check("add_ovf_sat_acc", 32'(acc), 32'b0111);
`endif
    check("add_ovf_flag", 32'(ovf), 32'd1);
    do_txn(OP_CLEAR, 4'b1010, 0);
    do_txn(OP_LOAD, 4'b0100, 0);
    do_txn(OP_SUB,  4'b0100, 0);
    do_txn(OP_LOAD, 4'b0100, 0);
    do_txn(OP_SUB,  4'b0101, 0);
    check("sub_borrow_acc", 32'(acc), 32'b1111);
    check("sub_borrow_carry", 32'(carry), 32'd0);
    do_txn(OP_LOAD, 4'b0111, 0);
    do_txn(OP_ADD,  4'b1000, 0);
    do_txn(OP_ADD,  4'b0001, 0);
    check("wrap_carry", 32'(carry), 32'd1);

    // backpressure with an ignored in_valid pulse
    do_txn(OP_ADD, 4'b0011, 5);

    // random commands with small random backpressure
    for (int n = 0; n < 30; n++) begin
      do_txn(2'($urandom_range(0, 3)), W'($urandom_range(0, (1 << W) - 1)),
             int'($urandom_range(0, 2)));
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/addsub_acc.md
# addsub_acc

Registered accumulator stage directly downstream of the 4-bit adder-subtractor. It accepts one command per transaction over a valid/ready handshake and uses its internal adder-subtractor as follows:

- the accumulator value drives operand A;
- the command operand drives B;
- the mode drives M.

It captures the sum or difference plus the carry-out into registers and presents the result with carry and signed-overflow flags over a second valid/ready handshake. This lets the arithmetic datapath chain operations (for example 4 + 4 - 5) without external registers.

## Interface
- WIDTH, 4, accumulator, operand and adder width in bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  command present
- in_ready  output  1  block can accept a command (high only in IDLE and while rst low)
- op  input  2  command: 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
- operand  input  WIDTH  B operand for ADD/SUB, load value for LOAD
- out_valid  output  1  result registered and presented
- out_ready  input  1  consumer accepts result
- acc  output  WIDTH  accumulator value (registered)
- carry  output  1  adder Cout of last ADD/SUB (for SUB: 1 = no borrow)
- ovf  output  1  two's-complement overflow of last ADD/SUB

## Operation
- FSM has three states: IDLE, EXEC and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid at a rising edge: latch op and operand, then go to EXEC.
- EXEC:
  - The adder sees A = acc, B = operand_q and M = (op_q == SUB).
  - At the next edge, acc, carry and ovf are updated per op_q, and the FSM goes to DONE.
- DONE:
  - out_valid = 1. acc, carry and ovf are held stable.
  - On out_ready at an edge, go to IDLE.
- Commands:
  - ADD: acc <= S, carry <= Cout.
  - SUB: acc <= S, where S = acc + ~operand + 1, carry <= Cout.
  - LOAD: acc <= operand, carry <= 0, ovf <= 0.
  - CLEAR: acc <= 0, carry <= 0, ovf <= 0.
- ovf definition: ovf = (A[W-1] == Bx[W-1]) && (S[W-1] != A[W-1]), where Bx = operand XOR {W{M}}.
- All arithmetic is modulo 2^WIDTH, and there is no sign extension. Cout is bit WIDTH of the W+1-bit sum.
- in_valid is ignored outside IDLE. operand and op only need to be valid in the accept cycle.
- Reset:
  - Asserting rst in any state forces IDLE immediately and zeroes acc, carry, ovf and out_valid.
  - An in-flight command is discarded.

## Timing
- Command accepted at edge k. Result is registered at edge k+1. out_valid is high from just after edge k+1.
- Result accepted at the first edge with out_valid && out_ready, at the earliest k+2. in_ready rises just after that edge.
- Maximum throughput is one command per 3 cycles. There is no combinational path from in_valid to out_valid, or from out_ready to in_ready.
- Reset values: acc = 0, carry = 0, ovf = 0, out_valid = 0. in_ready = 0 while rst is high and 1 in the first cycle after release.

## Configuration
- ACC_SAT_EN defined:
  - On ADD/SUB with signed overflow, acc clamps to 0111…1 if the true result is positive (A[W-1] = 0), or to 100…0 if it is negative.
  - ovf is still set, and carry is still the raw Cout.
- ACC_SAT_EN undefined: acc wraps to S.

## Structure
- Package addsub_acc_pkg holds:
  - op encodings: OP_ADD, OP_SUB, OP_LOAD, OP_CLEAR;
  - FSM state encodings: S_IDLE, S_EXEC, S_DONE;
  - default WIDTH = 4.
- One sub-module, addsub_core:
  - combinational WIDTH-bit ripple adder-subtractor;
  - ports A, B, M, S, Cout.
- The top block holds only the FSM, the operand/op registers, the flag logic and the saturation mux.

## Test plan
- Reset: assert rst for 2 cycles, including mid-EXEC after a LOAD 0101 -> acc = 0000, carry = 0, ovf = 0, out_valid = 0, in_ready = 1 one cycle after release.
- LOAD 0100, then ADD 0100 -> acc = 1000, carry = 0, ovf = 1. With ACC_SAT_EN -> acc = 0111, ovf = 1.
- LOAD 0100, SUB 0100 -> acc = 0000, carry = 1, ovf = 0. Then SUB 0101 from acc 0100 (reload 0100) -> acc = 1111, carry = 0, ovf = 0.
- LOAD 0111, ADD 1000 -> acc = 1111, carry = 0, ovf = 0. Then ADD 0001 -> acc = 0000, carry = 1, ovf = 0.
- Backpressure: hold out_ready low for 5 cycles in DONE -> out_valid and acc stay stable, in_ready = 0, and an in_valid pulse is ignored. With out_ready high, in_ready is next high at cycle k+2.
- CLEAR after an overflowing ADD (acc = 1000, ovf = 1) -> acc = 0000, carry = 0, ovf = 0.
